// File: rtl/config_pkg.sv
// ---------------------------------------------------------------------------
// config_pkg
// Shared configuration for the operand assembler: default widths, word and
// slot types, the header layout and the assembler state encoding.
// ---------------------------------------------------------------------------
package config_pkg;

    localparam int unsigned DATA_W  = 20;
    localparam int unsigned MAX_OPS = 4;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned CNT_W   = $clog2(MAX_OPS + 1);

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [2*DATA_W-1:0] w_data_t;
    typedef logic [CODE_W-1:0]   code_t;

    // Header word layout, LSB first: count, wide mask, code.
    // Bits above the code field are ignored.
    typedef struct packed {
        code_t              code;
        logic [MAX_OPS-1:0] wide_mask;
        logic [CNT_W-1:0]   count;
    } hdr_t;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,   // idle, next accepted word is a header
        ST_LOW  = 2'd1,   // next word is an operand low word (or the only word)
        ST_HIGH = 2'd2,   // next word is the upper word of a wide operand
        ST_OUT  = 2'd3    // assembled operation held for the consumer
    } asm_state_e;

endpackage : config_pkg

// File: rtl/operand_slot_reg.sv
// ---------------------------------------------------------------------------
// operand_slot_reg
// One 2*DATA_W operand slot. A low write loads the lower half and zeroes the
// upper half; a high write loads only the upper half. clr_i zeroes the slot.
//
// Ports:
//   clk      clock
//   srst_i   synchronous reset, active-high (slot reads zero)
//   clr_i    clear slot (new frame)
//   wr_lo_i  write data_i to the low half, upper half forced to zero
//   wr_hi_i  write data_i to the upper half
//   data_i   write data
//   slot_o   current slot contents
// ---------------------------------------------------------------------------
module operand_slot_reg #(
    parameter int unsigned DATA_W = 20
) (
    input  logic                clk,
    input  logic                srst_i,
    input  logic                clr_i,
    input  logic                wr_lo_i,
    input  logic                wr_hi_i,
    input  logic [DATA_W-1:0]   data_i,
    output logic [2*DATA_W-1:0] slot_o
);

    logic [2*DATA_W-1:0] data_q;
    logic [2*DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end
        if (wr_lo_i) begin
            data_d = {{DATA_W{1'b0}}, data_i};
        end
        if (wr_hi_i) begin
            data_d[2*DATA_W-1:DATA_W] = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign slot_o = data_q;

endmodule : operand_slot_reg

// File: rtl/operand_assembler.sv
// ---------------------------------------------------------------------------
// operand_assembler
// Consumes DATA_W-bit words, decodes a header (count, wide mask, code) and
// assembles up to MAX_OPS operands, each one word (narrow) or two words
// (wide, low word first). The result is offered with a valid/ready handshake;
// upstream is held off while an assembled operation waits.
//
// Ports:
//   clk                clock, rising edge
//   srst_i             synchronous reset, active-high
//   rd_data_valid_i    input word valid
//   rd_data_ready_o    input word accepted when valid && ready
//   rd_data_i          input word
//   operands_o         assembled operands, index 0 first
//   op_count_o         number of valid operands
//   code_o             operation code from the header
//   operation_valid_o  operation available
//   operation_ready_i  consumer accepts the operation
//   error_o            one-cycle pulse after a rejected header
// ---------------------------------------------------------------------------
module operand_assembler #(
    parameter int unsigned DATA_W  = config_pkg::DATA_W,
    parameter int unsigned MAX_OPS = config_pkg::MAX_OPS,
    parameter int unsigned CODE_W  = config_pkg::CODE_W,
    localparam int unsigned CNT_W  = $clog2(MAX_OPS + 1)
) (
    input  logic                              clk,
    input  logic                              srst_i,
    input  logic                              rd_data_valid_i,
    output logic                              rd_data_ready_o,
    input  logic [DATA_W-1:0]                 rd_data_i,
    output logic [MAX_OPS-1:0][2*DATA_W-1:0]  operands_o,
    output logic [CNT_W-1:0]                  op_count_o,
    output logic [CODE_W-1:0]                 code_o,
    output logic                              operation_valid_o,
    input  logic                              operation_ready_i,
    output logic                              error_o
);

    import config_pkg::*;

    if (CNT_W + MAX_OPS + CODE_W > DATA_W) begin : g_bad_cfg
        $error("operand_assembler: header fields do not fit in DATA_W");
    end

    asm_state_e         state_q;
    logic [CNT_W-1:0]   idx_q;
    logic [CNT_W-1:0]   last_q;     // N-1, so the end-of-frame test is a plain compare
    logic [CNT_W-1:0]   count_q;
    logic [MAX_OPS-1:0] mask_q;
    logic [CODE_W-1:0]  code_q;
    logic               valid_q;
    logic               ready_q;
    logic               error_q;

    // Header field decode
    logic [CNT_W-1:0]   hdr_count;
    logic [MAX_OPS-1:0] hdr_mask;
    logic [CODE_W-1:0]  hdr_code;
    logic               hdr_ok;

    assign hdr_count = rd_data_i[CNT_W-1:0];
    assign hdr_mask  = rd_data_i[CNT_W +: MAX_OPS];
    assign hdr_code  = rd_data_i[CNT_W+MAX_OPS +: CODE_W];
    assign hdr_ok    = (hdr_count != '0) && (hdr_count <= CNT_W'(MAX_OPS));

    logic accept;
    logic idx_is_last;
    logic cur_wide;

    assign accept      = rd_data_valid_i && ready_q;
    assign idx_is_last = (idx_q == last_q);

    // Mask lookup by compare rather than direct indexing: idx_q is wider
    // than needed to address MAX_OPS bits.
    always_comb begin
        cur_wide = 1'b0;
        for (int i = 0; i < int'(MAX_OPS); i++) begin
            if (idx_q == CNT_W'(i)) begin
                cur_wide = mask_q[i];
            end
        end
    end

    // Slot write controls
    logic               slot_clr;
    logic [MAX_OPS-1:0] lo_en;
    logic [MAX_OPS-1:0] hi_en;

    assign slot_clr = accept && (state_q == ST_HDR) && hdr_ok;

    for (genvar gi = 0; gi < int'(MAX_OPS); gi++) begin : g_slot
        assign lo_en[gi] = accept && (state_q == ST_LOW)  && (idx_q == CNT_W'(gi));
        assign hi_en[gi] = accept && (state_q == ST_HIGH) && (idx_q == CNT_W'(gi));

        operand_slot_reg #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .srst_i  (srst_i),
            .clr_i   (slot_clr),
            .wr_lo_i (lo_en[gi]),
            .wr_hi_i (hi_en[gi]),
            .data_i  (rd_data_i),
            .slot_o  (operands_o[gi])
        );
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (srst_i) begin
            state_q <= ST_HDR;
            idx_q   <= '0;
            last_q  <= '0;
            count_q <= '0;
            mask_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                ST_HDR: begin
                    if (accept) begin
                        if (!hdr_ok) begin
                            error_q <= 1'b1;
                        end else begin
                            count_q <= hdr_count;
                            last_q  <= hdr_count - CNT_W'(1);
                            mask_q  <= hdr_mask;
                            code_q  <= hdr_code;
                            idx_q   <= '0;
                            state_q <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    if (accept) begin
                        if (cur_wide) begin
                            state_q <= ST_HIGH;
                        end else if (idx_is_last) begin
                            state_q <= ST_OUT;
                            valid_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + CNT_W'(1);
                        end
                    end
                end
                ST_HIGH: begin
                    if (accept) begin
                        if (idx_is_last) begin
                            state_q <= ST_OUT;
                            valid_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + CNT_W'(1);
                            state_q <= ST_LOW;
                        end
                    end
                end
                ST_OUT: begin
                    if (operation_ready_i) begin
                        state_q <= ST_HDR;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_HDR;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign rd_data_ready_o   = ready_q;
    assign op_count_o        = count_q;
    assign code_o            = code_q;
    assign operation_valid_o = valid_q;
    assign error_o           = error_q;

endmodule : operand_assembler

// File: tb/tb_operand_assembler.sv
module tb_operand_assembler;

    logic              clk;
    logic              srst;
    logic              rvalid;
    logic              rready;
    logic [19:0]       rdata;
    logic [3:0][39:0]  ops;
    logic [2:0]        cnt;
    logic [3:0]        code;
    logic              ovalid;
    logic              oready;
    logic              err;

    int n_cmp  = 0;
    int n_fail = 0;

    operand_assembler dut (
        .clk               (clk),
        .srst_i            (srst),
        .rd_data_valid_i   (rvalid),
        .rd_data_ready_o   (rready),
        .rd_data_i         (rdata),
        .operands_o        (ops),
        .op_count_o        (cnt),
        .code_o            (code),
        .operation_valid_o (ovalid),
        .operation_ready_i (oready),
        .error_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word and let it be clocked in.
    task automatic put(input logic [19:0] w);
        rvalid = 1'b1;
        rdata  = w;
        tick();
        rvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        rvalid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        srst   = 1'b1;
        rvalid = 1'b0;
        rdata  = '0;
        oready = 1'b1;
        tick();
        tick();
        $display("reset: ready=%0d valid=%0d cnt=%0d code=%0d err=%0d", rready, ovalid, cnt, code, err);
        chk("rst_ready", 64'(rready), 64'd1);
        chk("rst_valid", 64'(ovalid), 64'd0);
        chk("rst_cnt",   64'(cnt),    64'd0);
        chk("rst_code",  64'(code),   64'd0);
        chk("rst_err",   64'(err),    64'd0);
        chk("rst_op0",   64'(ops[0]), 64'd0);
        srst = 1'b0;
        tick();

        // ---- Mixed frame, back-to-back, consumer always ready ----
        put(20'h002A3);
        chk("mix_hdr_err", 64'(err), 64'd0);
        chk("mix_hdr_cnt", 64'(cnt), 64'd3);
        put(20'hABCDE);
        put(20'hDEADF);
        put(20'hCAFEA);
        chk("mix_pre_valid", 64'(ovalid), 64'd0);
        put(20'hFADED);
        $display("mixed: valid=%0d op0=%h op1=%h op2=%h op3=%h cnt=%0d code=%0d",
                 ovalid, ops[0], ops[1], ops[2], ops[3], cnt, code);
        chk("mix_valid", 64'(ovalid), 64'd1);
        chk("mix_ready", 64'(rready), 64'd0);
        chk("mix_op0",   64'(ops[0]), 64'h00000ABCDE);
        chk("mix_op1",   64'(ops[1]), 64'h00000DEADF);
        chk("mix_op2",   64'(ops[2]), 64'hFADEDCAFEA);
        chk("mix_op3",   64'(ops[3]), 64'h0);
        chk("mix_cnt",   64'(cnt),    64'd3);
        chk("mix_code",  64'(code),   64'd5);
        tick();
        chk("mix_valid_drop", 64'(ovalid), 64'd0);
        chk("mix_ready_back", 64'(rready), 64'd1);

        // ---- Bad headers ----
        put(20'h00000);
        $display("bad hdr N=0: err=%0d", err);
        chk("bad0_err", 64'(err), 64'd1);
        put(20'h00005);
        $display("bad hdr N=5: err=%0d", err);
        chk("bad5_err",   64'(err),    64'd1);
        chk("bad5_valid", 64'(ovalid), 64'd0);
        chk("bad5_cnt",   64'(cnt),    64'd3);
        idle(1);
        chk("bad_err_clr", 64'(err),    64'd0);
        chk("bad_ready",   64'(rready), 64'd1);
        put(20'h00001);
        chk("n1_valid_early", 64'(ovalid), 64'd0);
        put(20'h12345);
        $display("N=1: valid=%0d op0=%h op1=%h cnt=%0d", ovalid, ops[0], ops[1], cnt);
        chk("n1_valid", 64'(ovalid), 64'd1);
        chk("n1_op0",   64'(ops[0]), 64'h0000012345);
        chk("n1_op1",   64'(ops[1]), 64'h0);
        chk("n1_op2",   64'(ops[2]), 64'h0);
        chk("n1_cnt",   64'(cnt),    64'd1);
        chk("n1_code",  64'(code),   64'd0);
        tick();

        // ---- Backpressure, next header already presented ----
        oready = 1'b0;
        put(20'h002A3);
        put(20'hABCDE);
        put(20'hDEADF);
        put(20'hCAFEA);
        put(20'hFADED);
        rvalid = 1'b1;
        rdata  = 20'h001FC;   // N=4, mask=1111, code=3
        for (int c = 0; c < 3; c++) begin
            $display("stall cycle %0d: valid=%0d ready=%0d op2=%h cnt=%0d", c, ovalid, rready, ops[2], cnt);
            chk("bp_valid", 64'(ovalid), 64'd1);
            chk("bp_ready", 64'(rready), 64'd0);
            chk("bp_op2",   64'(ops[2]), 64'hFADEDCAFEA);
            chk("bp_op0",   64'(ops[0]), 64'h00000ABCDE);
            chk("bp_cnt",   64'(cnt),    64'd3);
            chk("bp_code",  64'(code),   64'd5);
            if (c < 2) tick();
        end
        oready = 1'b1;
        tick();                 // handshake edge: header must not be taken
        chk("bp_hs_valid", 64'(ovalid), 64'd0);
        chk("bp_hs_ready", 64'(rready), 64'd1);
        chk("bp_hs_cnt",   64'(cnt),    64'd3);
        tick();                 // header accepted here
        rvalid = 1'b0;
        $display("header after handshake: cnt=%0d code=%0d", cnt, code);
        chk("bp_hdr_cnt",  64'(cnt),    64'd4);
        chk("bp_hdr_code", 64'(code),   64'd3);
        chk("bp_hdr_op0",  64'(ops[0]), 64'h0);

        // ---- Full width: continue the frame whose header was just taken ----
        put(20'h01111);
        put(20'h12222);
        put(20'h23333);
        put(20'h34444);
        put(20'h45555);
        put(20'h56666);
        put(20'h67777);
        chk("fw_pre_valid", 64'(ovalid), 64'd0);
        put(20'h78888);
        $display("full width: valid=%0d op0=%h op1=%h op2=%h op3=%h cnt=%0d",
                 ovalid, ops[0], ops[1], ops[2], ops[3], cnt);
        chk("fw_valid", 64'(ovalid), 64'd1);
        chk("fw_op0",   64'(ops[0]), 64'h1222201111);
        chk("fw_op1",   64'(ops[1]), 64'h3444423333);
        chk("fw_op2",   64'(ops[2]), 64'h5666645555);
        chk("fw_op3",   64'(ops[3]), 64'h7888867777);
        chk("fw_cnt",   64'(cnt),    64'd4);
        tick();
        chk("fw_valid_drop", 64'(ovalid), 64'd0);

        // ---- Bubbles: two idle cycles between every word ----
        put(20'h002A3);
        idle(2);
        put(20'hABCDE);
        idle(2);
        put(20'hDEADF);
        idle(2);
        put(20'hCAFEA);
        idle(2);
        chk("bub_pre_valid", 64'(ovalid), 64'd0);
        put(20'hFADED);
        $display("bubbles: valid=%0d op0=%h op1=%h op2=%h", ovalid, ops[0], ops[1], ops[2]);
        chk("bub_valid", 64'(ovalid), 64'd1);
        chk("bub_op0",   64'(ops[0]), 64'h00000ABCDE);
        chk("bub_op1",   64'(ops[1]), 64'h00000DEADF);
        chk("bub_op2",   64'(ops[2]), 64'hFADEDCAFEA);
        chk("bub_op3",   64'(ops[3]), 64'h0);
        tick();

        // ---- Mid-frame reset ----
        put(20'h002A3);
        put(20'hABCDE);
        put(20'hDEADF);
        chk("mr_pre_op1", 64'(ops[1]), 64'h00000DEADF);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        $display("after mid-frame reset: op0=%h op1=%h cnt=%0d code=%0d valid=%0d ready=%0d",
                 ops[0], ops[1], cnt, code, ovalid, rready);
        chk("mr_op0",   64'(ops[0]), 64'h0);
        chk("mr_op1",   64'(ops[1]), 64'h0);
        chk("mr_cnt",   64'(cnt),    64'd0);
        chk("mr_code",  64'(code),   64'd0);
        chk("mr_valid", 64'(ovalid), 64'd0);
        chk("mr_ready", 64'(rready), 64'd1);
        put(20'h002A3);
        chk("mr_hdr_cnt", 64'(cnt), 64'd3);
        put(20'hABCDE);
        put(20'hDEADF);
        put(20'hCAFEA);
        put(20'hFADED);
        $display("post-reset frame: valid=%0d op2=%h", ovalid, ops[2]);
        chk("mr2_valid", 64'(ovalid), 64'd1);
        chk("mr2_op0",   64'(ops[0]), 64'h00000ABCDE);
        chk("mr2_op2",   64'(ops[2]), 64'hFADEDCAFEA);
        chk("mr2_code",  64'(code),   64'd5);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_operand_assembler

// File: doc/operand_assembler.md
# operand_assembler

Parametrised successor to the fixed three-operand receive FSM. Consumes a stream of `DATA_W`-bit words from the read-data path, decodes a header word, and assembles up to `MAX_OPS` operands. Each operand is either narrow (1 word) or wide (2 words). Presents the result as one operation with a valid/ready handshake to the execute stage. Applies backpressure upstream while an assembled operation is waiting.

## Interface
Parameters:
- `DATA_W`, 20, input word width (`data_t`); operand slot width is `2*DATA_W` (`w_data_t`)
- `MAX_OPS`, 4, maximum operands per operation
- `CODE_W`, 4, operation code field width (`code_t`)
- Derived: `CNT_W = $clog2(MAX_OPS+1)`
- Constraint: `CNT_W + MAX_OPS + CODE_W <= DATA_W`; checked by elaboration assertion.

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `srst_i`  in  1  synchronous reset, active-high
- `rd_data_valid_i`  in  1  input word valid
- `rd_data_ready_o`  out  1  input word accepted when valid && ready
- `rd_data_i`  in  DATA_W  input word
- `operands_o`  out  MAX_OPS x 2*DATA_W  assembled operands, index 0 first
- `op_count_o`  out  CNT_W  number of valid operands
- `code_o`  out  CODE_W  operation code from header
- `operation_valid_o`  out  1  operation available
- `operation_ready_i`  in  1  consumer accepts operation
- `error_o`  out  1  one-cycle pulse on rejected header

## Operation
- Header word fields:
  - `[CNT_W-1:0]` = count N
  - `[CNT_W +: MAX_OPS]` = wide mask, bit i set means operand i is wide
  - `[CNT_W+MAX_OPS +: CODE_W]` = code
  - Remaining bits are ignored.
- States:
  - HDR: idle / await header.
  - LOW: await operand low word, or the only word if narrow.
  - HIGH: await upper word of a wide operand.
  - OUT: hold assembled operation.
- HDR, accepted word:
  - N == 0 or N > MAX_OPS: pulse `error_o`, stay in HDR; nothing else changes.
  - Otherwise latch code, N and mask; clear all operand slots; index = 0; go to LOW.
- LOW, accepted word: write it to `operands[idx][DATA_W-1:0]` with the upper half zero.
  - If mask[idx] is set, go to HIGH.
  - Else, if idx == N-1, go to OUT; otherwise idx++ and stay in LOW.
- HIGH, accepted word: write it to `operands[idx][2*DATA_W-1:DATA_W]`.
  - If idx == N-1, go to OUT; otherwise idx++ and go to LOW.
- OUT: `operation_valid_o` = 1. On `operation_ready_i`, go to HDR.
- `rd_data_ready_o` = 1 in HDR, LOW and HIGH; 0 in OUT. There is no bypass.
- Mask bits at index >= N are ignored. Slots at index >= N read zero.
- A cycle with `rd_data_valid_i` = 0 causes no state change. Gaps between words are unlimited.

## Timing
- Reset (sync, dominant over all other inputs): state HDR, `operands_o` all 0, `op_count_o` 0, `code_o` 0, `operation_valid_o` 0, `error_o` 0. `rd_data_ready_o` is 1 in the first cycle after reset.
- `srst_i` mid-frame discards the partial frame. The next accepted word is treated as a header.
- Latency: `operation_valid_o` rises on the clock edge that accepts the final payload word. It is visible the cycle after that word is presented.
- Minimum frame length is 1 + N + popcount(mask[N-1:0]) cycles, plus one cycle for the OUT handshake.
- All outputs are stable while `operation_valid_o` = 1 && `operation_ready_i` = 0.
- `error_o` is registered and rises the cycle after the bad header is accepted.
- `op_count_o` and `code_o` update when a header is accepted. They are meaningful only while `operation_valid_o` = 1.

## Structure
- Add `DATA_W`, `MAX_OPS` and `CODE_W` defaults to `config_pkg`, alongside `data_t`, `w_data_t` and `code_t`.
- Add to `config_pkg`: a `hdr_t` packed struct {code, wide_mask, count}, and a state enum `asm_state_e`.
- One sub-module: `operand_slot_reg`, a per-operand 2*DATA_W register with separate low/high write enables and a clear input, instantiated `MAX_OPS` times.

## Test plan
- **Mixed frame.**
  - Stimulus: header `20'h002A3` (N=3, mask=4'b0100, code=5), then `ABCDE`, `DEADF`, `CAFEA`, `FADED` back-to-back, with `operation_ready_i` held at 1.
  - Response: `operands_o` = {0, `FADEDCAFEA`, `00000DEADF`, `00000ABCDE`}, `op_count_o`=3, `code_o`=5, `operation_valid_o` high for one cycle, the cycle after `FADED` is accepted.
- **Bad headers.**
  - Stimulus: header `20'h00000`, then `20'h00005`.
  - Response: two `error_o` pulses, state remains HDR, no `operation_valid_o`.
  - Then: header `20'h00001` followed by `12345` gives operand0 = `0000012345`.
- **Backpressure.**
  - Stimulus: repeat the mixed frame with `operation_ready_i` low for 3 cycles and the next header already presented.
  - Response: outputs stable and `rd_data_ready_o` = 0 for all 3 cycles; the header is accepted only in the cycle after the handshake.
- **Bubbles.**
  - Stimulus: the mixed frame with `rd_data_valid_i` low for 2 cycles between every word.
  - Response: identical result, with valid delayed by exactly the bubble count.
- **Mid-frame reset.**
  - Stimulus: `srst_i` asserted after header + 2 words.
  - Response: all outputs zero the next cycle; a subsequent full frame assembles correctly.
- **Full width.**
  - Stimulus: N=4, mask=4'b1111, 8 payload words.
  - Response: all four slots wide, with each low word first.
